dm_access_ctrl: RTL

Load/store access controller sitting directly upstream of the SISC data memory. Accepts one load or store request at a time from the processor control path over a valid/ready handshake. Drives the data memory's read address, write address, write data and write-enable pins. The data memory commits a store on the falling edge of `dm_we`, so the controller sequences a clean setup → pulse → release write. It returns load data, or a store acknowledgement, over a valid/ready response channel and rejects out-of-range addresses.

---
 rtl/sisc_dm_pkg.sv | 15 +
 rtl/dm_access_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sisc_dm_pkg.sv
// Shared definitions for the SISC data-memory access path.
`timescale 1ns/1ps
package sisc_dm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        RESP
    } dm_state_e;

    localparam logic [15:0] DM_ADDR_MAX = 16'd65532;

endpackage

// File: rtl/dm_access_ctrl.sv
// Load/store controller for the SISC data memory: one request in flight, range check,
// setup/pulse/release store sequencing and a registered response channel.
`timescale 1ns/1ps
module dm_access_ctrl
    import sisc_dm_pkg::*;
#(
    parameter logic [15:0] ADDR_MAX = DM_ADDR_MAX,
    parameter int          ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [15:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [15:0]         dm_read_addr,
    output logic [15:0]         dm_write_addr,
    output logic [31:0]         dm_write_data,
    output logic                dm_we,
    input  logic [31:0]         dm_read_data
);

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    endfunction

    dm_state_e             state_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;
    logic [ERRCNT_W-1:0]   err_count_q;
    logic [ERRCNT_W-1:0]   err_count_d;
    logic [15:0]           dm_read_addr_q;
    logic [15:0]           dm_write_addr_q;
    logic [31:0]           dm_write_data_q;
    logic                  dm_we_q;
    logic                  addr_bad;

    assign addr_bad = (req_addr > ADDR_MAX);

    always_comb begin
        err_count_d = sat_inc(err_count_q);
    end

    // dm_we and rsp_valid are registered decodes of the state, so each lags its
    // state by one edge: the write pulse sits one cycle after WR_PULSE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
            err_count_q     <= '0;
            dm_read_addr_q  <= '0;
            dm_write_addr_q <= '0;
            dm_write_data_q <= '0;
            dm_we_q         <= 1'b0;
        end else begin
            dm_we_q <= (state_q == WR_PULSE);
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        if (addr_bad) begin
                            rsp_err_q   <= 1'b1;
                            err_count_q <= err_count_d;
                            state_q     <= RESP;
                        end else begin
                            rsp_err_q <= 1'b0;
                            if (req_we) begin
                                dm_write_addr_q <= req_addr;
                                dm_write_data_q <= req_wdata;
                                state_q         <= WR_SETUP;
                            end else begin
                                dm_read_addr_q <= req_addr;
                                state_q        <= RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    rsp_rdata_q <= dm_read_data;
                    state_q     <= RESP;
                end
                WR_SETUP: begin
                    state_q <= WR_PULSE;
                end
                WR_PULSE: begin
                    state_q <= RESP;
                end
                RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign err_count     = err_count_q;
    assign dm_read_addr  = dm_read_addr_q;
    assign dm_write_addr = dm_write_addr_q;
    assign dm_write_data = dm_write_data_q;
    assign dm_we         = dm_we_q;

endmodule
